// File: rtl/control_principal_multiciclo.sv
// rtl/control_principal_multiciclo.sv - multicycle MIPS main control unit (Moore FSM)
//
// Purpose:
//   Sequences the multicycle datapath through fetch, decode, execute, memory
//   and writeback steps. It decodes the opcode held in the instruction
//   register, waits on a memory-ready handshake and counts retired
//   instructions.
//
// Ports:
//   i_clk          clock, rising edge
//   i_reset        synchronous, active-high reset
//   i_Opcode       IR[31:26]
//   i_MemReady     memory finished the current read/write this cycle
//   o_PCWrite      unconditional PC write
//   o_PCWriteCond  PC write if ALU zero
//   o_IorD         memory address select (0 = PC, 1 = ALUOut)
//   o_MemRead      memory read request
//   o_MemWrite     memory write request
//   o_MemtoReg     register write data select (1 = MDR)
//   o_IRWrite      instruction register load
//   o_PCSource     PC source (00 = ALU, 01 = ALUOut, 10 = jump target)
//   o_ALUOp        to ALU control (00 = add, 01 = sub, 10 = funct)
//   o_ALUSrcA      ALU A select (0 = PC, 1 = regA)
//   o_ALUSrcB      ALU B select (00 = regB, 01 = 4, 10 = imm, 11 = imm << 2)
//   o_RegWrite     register file write
//   o_RegDst       destination select (1 = rd, 0 = rt)
//   o_Illegal      unknown opcode seen in DECODE
//   o_State        current state register, for debug
//   o_InstrCount   retired-instruction count, wraps

module control_principal_multiciclo #(
  parameter int NBITSOP      = 6,
  parameter int NBITSCONTROL = 2,
  parameter int NBITSCNT     = 32
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic [NBITSOP-1:0]      i_Opcode,
  input  logic                    i_MemReady,
  output logic                    o_PCWrite,
  output logic                    o_PCWriteCond,
  output logic                    o_IorD,
  output logic                    o_MemRead,
  output logic                    o_MemWrite,
  output logic                    o_MemtoReg,
  output logic                    o_IRWrite,
  output logic [1:0]              o_PCSource,
  output logic [NBITSCONTROL-1:0] o_ALUOp,
  output logic                    o_ALUSrcA,
  output logic [1:0]              o_ALUSrcB,
  output logic                    o_RegWrite,
  output logic                    o_RegDst,
  output logic                    o_Illegal,
  output logic [3:0]              o_State,
  output logic [NBITSCNT-1:0]     o_InstrCount
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADDR  = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTE  = 4'd6,
    RTYPEWB  = 4'd7,
    BRANCH   = 4'd8,
    JUMP     = 4'd9
  } state_t;

  localparam logic [NBITSOP-1:0] OP_RTYPE = NBITSOP'(6'b000000);
  localparam logic [NBITSOP-1:0] OP_LW    = NBITSOP'(6'b100011);
  localparam logic [NBITSOP-1:0] OP_SW    = NBITSOP'(6'b101011);
  localparam logic [NBITSOP-1:0] OP_BEQ   = NBITSOP'(6'b000100);
  localparam logic [NBITSOP-1:0] OP_J     = NBITSOP'(6'b000010);

  localparam logic [NBITSCONTROL-1:0] ALU_ADD   = NBITSCONTROL'(2'b00);
  localparam logic [NBITSCONTROL-1:0] ALU_SUB   = NBITSCONTROL'(2'b01);
  localparam logic [NBITSCONTROL-1:0] ALU_FUNCT = NBITSCONTROL'(2'b10);

  // Per-state control word. is_fetch / is_decode mark the two states whose
  // outputs also depend on live inputs (ready handshake, opcode legality).
  typedef struct packed {
    logic                    pc_write;
    logic                    pc_write_cond;
    logic                    iord;
    logic                    mem_read;
    logic                    mem_write;
    logic                    mem_to_reg;
    logic                    ir_write;
    logic [1:0]              pc_source;
    logic [NBITSCONTROL-1:0] alu_op;
    logic                    alu_src_a;
    logic [1:0]              alu_src_b;
    logic                    reg_write;
    logic                    reg_dst;
    logic                    is_fetch;
    logic                    is_decode;
  } ctrl_t;

  function automatic ctrl_t decode_state(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = 2'b01;
        c.alu_op    = ALU_ADD;
        c.ir_write  = 1'b1;
        c.pc_write  = 1'b1;
        c.is_fetch  = 1'b1;
      end
      DECODE: begin
        c.alu_src_b = 2'b11;
        c.alu_op    = ALU_ADD;
        c.is_decode = 1'b1;
      end
      MEMADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        c.alu_op    = ALU_ADD;
      end
      MEMREAD: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      MEMWB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      MEMWRITE: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
      end
      EXECUTE: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b00;
        c.alu_op    = ALU_FUNCT;
      end
      RTYPEWB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_src_b     = 2'b00;
        c.alu_op        = ALU_SUB;
        c.pc_write_cond = 1'b1;
        c.pc_source     = 2'b01;
      end
      JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = 2'b10;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  state_t              state;
  state_t              next_state;
  ctrl_t               ctrl;
  logic [NBITSCNT-1:0] instr_count;
  logic                retire;
  logic                opcode_known;

  always_comb begin
    opcode_known = (i_Opcode == OP_RTYPE) || (i_Opcode == OP_LW) ||
                   (i_Opcode == OP_SW)    || (i_Opcode == OP_BEQ) ||
                   (i_Opcode == OP_J);
  end

  always_comb begin
    next_state = FETCH;
    retire     = 1'b0;
    case (state)
      FETCH:   next_state = i_MemReady ? DECODE : FETCH;
      DECODE: begin
        if (i_Opcode == OP_RTYPE)                         next_state = EXECUTE;
        else if ((i_Opcode == OP_LW) || (i_Opcode == OP_SW)) next_state = MEMADDR;
        else if (i_Opcode == OP_BEQ)                      next_state = BRANCH;
        else if (i_Opcode == OP_J)                        next_state = JUMP;
        else                                              next_state = FETCH;
      end
      // The IR only loads in FETCH, so the opcode is still valid here.
      MEMADDR: next_state = (i_Opcode == OP_SW) ? MEMWRITE : MEMREAD;
      MEMREAD: next_state = i_MemReady ? MEMWB : MEMREAD;
      MEMWRITE: begin
        next_state = i_MemReady ? FETCH : MEMWRITE;
        retire     = i_MemReady;
      end
      EXECUTE: next_state = RTYPEWB;
      MEMWB, RTYPEWB, BRANCH, JUMP: begin
        next_state = FETCH;
        retire     = 1'b1;
      end
      default: next_state = FETCH;
    endcase
  end

  // State, counter and the registered control word all move together; the
  // control word is precomputed from the next state so it lines up with it.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state       <= FETCH;
      ctrl        <= decode_state(FETCH);
      instr_count <= '0;
    end else begin
      state <= next_state;
      ctrl  <= decode_state(next_state);
      if (retire) begin
        instr_count <= instr_count + NBITSCNT'(1);
      end
    end
  end

  // Reset masks every control output. In FETCH the IR/PC load only happens
  // on the cycle memory delivers the instruction.
  always_comb begin
    o_PCWrite     = 1'b0;
    o_PCWriteCond = 1'b0;
    o_IorD        = 1'b0;
    o_MemRead     = 1'b0;
    o_MemWrite    = 1'b0;
    o_MemtoReg    = 1'b0;
    o_IRWrite     = 1'b0;
    o_PCSource    = 2'b00;
    o_ALUOp       = '0;
    o_ALUSrcA     = 1'b0;
    o_ALUSrcB     = 2'b00;
    o_RegWrite    = 1'b0;
    o_RegDst      = 1'b0;
    o_Illegal     = 1'b0;
    if (!i_reset) begin
      o_PCWrite     = ctrl.pc_write & (i_MemReady | ~ctrl.is_fetch);
      o_PCWriteCond = ctrl.pc_write_cond;
      o_IorD        = ctrl.iord;
      o_MemRead     = ctrl.mem_read;
      o_MemWrite    = ctrl.mem_write;
      o_MemtoReg    = ctrl.mem_to_reg;
      o_IRWrite     = ctrl.ir_write & i_MemReady;
      o_PCSource    = ctrl.pc_source;
      o_ALUOp       = ctrl.alu_op;
      o_ALUSrcA     = ctrl.alu_src_a;
      o_ALUSrcB     = ctrl.alu_src_b;
      o_RegWrite    = ctrl.reg_write;
      o_RegDst      = ctrl.reg_dst;
      o_Illegal     = ctrl.is_decode & ~opcode_known;
    end
  end

  assign o_State      = state;
  assign o_InstrCount = instr_count;

endmodule

// File: tb/tb_control_principal_multiciclo.sv
// tb/tb_control_principal_multiciclo.sv - self-checking bench for control_principal_multiciclo
module tb_control_principal_multiciclo;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          rdy;
  logic [5:0]    op;
  logic          pcw, pcwc, iord, mr, mw, m2r, irw, asa, rw, rd, ill;
  logic [1:0]    pcs, aluop, asb;
  logic [3:0]    st;
  logic [CW-1:0] cnt;
  logic [16:0]   obs;

  int checks = 0;
  int errors = 0;
  int model_count = 0;

  control_principal_multiciclo #(.NBITSOP(6), .NBITSCONTROL(2), .NBITSCNT(CW)) dut (
    .i_clk(clk), .i_reset(rst), .i_Opcode(op), .i_MemReady(rdy),
    .o_PCWrite(pcw), .o_PCWriteCond(pcwc), .o_IorD(iord), .o_MemRead(mr),
    .o_MemWrite(mw), .o_MemtoReg(m2r), .o_IRWrite(irw), .o_PCSource(pcs),
    .o_ALUOp(aluop), .o_ALUSrcA(asa), .o_ALUSrcB(asb), .o_RegWrite(rw),
    .o_RegDst(rd), .o_Illegal(ill), .o_State(st), .o_InstrCount(cnt)
  );

  always #5 clk = ~clk;

  assign obs = {pcw, pcwc, iord, mr, mw, m2r, irw, pcs, aluop, asa, asb, rw, rd, ill};

  function automatic logic [16:0] mk(input logic a_pcw, input logic a_pcwc, input logic a_iord,
                                     input logic a_mr, input logic a_mw, input logic a_m2r,
                                     input logic a_irw, input logic [1:0] a_pcs,
                                     input logic [1:0] a_aluop, input logic a_asa,
                                     input logic [1:0] a_asb, input logic a_rw,
                                     input logic a_rd, input logic a_ill);
    return {a_pcw, a_pcwc, a_iord, a_mr, a_mw, a_m2r, a_irw, a_pcs, a_aluop, a_asa, a_asb, a_rw, a_rd, a_ill};
  endfunction

  logic [16:0] c_zero, c_fw, c_fr, c_dec, c_dec_ill, c_maddr, c_mread, c_mwb, c_mwrite;
  logic [16:0] c_exec, c_rwb, c_br, c_jmp;

  task automatic cycle(input string tag, input logic [3:0] exp_st, input logic [16:0] exp_ctl,
                       input bit retire);
    #2;
    checks++;
    assert (st === exp_st) else begin
      errors++;
      $error("FAIL %s state got %0d want %0d", tag, st, exp_st);
    end
    checks++;
    assert (obs === exp_ctl) else begin
      errors++;
      $error("FAIL %s ctrl got %b want %b", tag, obs, exp_ctl);
    end
    checks++;
    assert (cnt === CW'(model_count)) else begin
      errors++;
      $error("FAIL %s count got %0d want %0d", tag, cnt, model_count);
    end
    @(posedge clk);
    #1;
    if (retire) model_count = (model_count + 1) % (1 << CW);
  endtask

  // One complete instruction: fetch_wait / mem_wait cycles of ready low in
  // the fetch and memory wait states; ready is random where it must be ignored.
  task automatic run_instr(input logic [5:0] opc, input int fetch_wait, input int mem_wait);
    bit known;
    op = opc;
    known = (opc == 6'b000000) || (opc == 6'b100011) || (opc == 6'b101011) ||
            (opc == 6'b000100) || (opc == 6'b000010);
    for (int i = 0; i < fetch_wait; i++) begin
      rdy = 1'b0;
      cycle("fetch_wait", 4'd0, c_fw, 1'b0);
    end
    rdy = 1'b1;
    cycle("fetch", 4'd0, c_fr, 1'b0);
    rdy = 1'($urandom_range(0, 1));
    cycle("decode", 4'd1, known ? c_dec : c_dec_ill, 1'b0);
    case (opc)
      6'b000000: begin
        rdy = 1'($urandom_range(0, 1));
        cycle("execute", 4'd6, c_exec, 1'b0);
        rdy = 1'($urandom_range(0, 1));
        cycle("rtypewb", 4'd7, c_rwb, 1'b1);
      end
      6'b100011: begin
        rdy = 1'($urandom_range(0, 1));
        cycle("memaddr_lw", 4'd2, c_maddr, 1'b0);
        for (int i = 0; i < mem_wait; i++) begin
          rdy = 1'b0;
          cycle("memread_wait", 4'd3, c_mread, 1'b0);
        end
        rdy = 1'b1;
        cycle("memread", 4'd3, c_mread, 1'b0);
        rdy = 1'($urandom_range(0, 1));
        cycle("memwb", 4'd4, c_mwb, 1'b1);
      end
      6'b101011: begin
        rdy = 1'($urandom_range(0, 1));
        cycle("memaddr_sw", 4'd2, c_maddr, 1'b0);
        for (int i = 0; i < mem_wait; i++) begin
          rdy = 1'b0;
          cycle("memwrite_wait", 4'd5, c_mwrite, 1'b0);
        end
        rdy = 1'b1;
        cycle("memwrite", 4'd5, c_mwrite, 1'b1);
      end
      6'b000100: begin
        rdy = 1'($urandom_range(0, 1));
        cycle("branch", 4'd8, c_br, 1'b1);
      end
      6'b000010: begin
        rdy = 1'($urandom_range(0, 1));
        cycle("jump", 4'd9, c_jmp, 1'b1);
      end
      default: ;
    endcase
  endtask

  initial begin
    logic [5:0] ops [6];
    logic [5:0] r;
    c_zero    = '0;
    c_fw      = mk(0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 0, 2'b01, 0, 0, 0);
    c_fr      = mk(1, 0, 0, 1, 0, 0, 1, 2'b00, 2'b00, 0, 2'b01, 0, 0, 0);
    c_dec     = mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b11, 0, 0, 0);
    c_dec_ill = mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b11, 0, 0, 1);
    c_maddr   = mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 2'b10, 0, 0, 0);
    c_mread   = mk(0, 0, 1, 1, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, 0, 0, 0);
    c_mwb     = mk(0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 0, 2'b00, 1, 0, 0);
    c_mwrite  = mk(0, 0, 1, 0, 1, 0, 0, 2'b00, 2'b00, 0, 2'b00, 0, 0, 0);
    c_exec    = mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 1, 2'b00, 0, 0, 0);
    c_rwb     = mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, 1, 1, 0);
    c_br      = mk(0, 1, 0, 0, 0, 0, 0, 2'b01, 2'b01, 1, 2'b00, 0, 0, 0);
    c_jmp     = mk(1, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 0, 2'b00, 0, 0, 0);

    // Reset held two cycles: outputs masked, state FETCH, count zero.
    rst = 1'b1;
    rdy = 1'b1;
    op  = 6'b000000;
    @(posedge clk);
    #1;
    cycle("reset0", 4'd0, c_zero, 1'b0);
    cycle("reset1", 4'd0, c_zero, 1'b0);
    rst = 1'b0;

    // Directed: R-type, lw with 3 waits, beq, j, illegal, sw with waits.
    run_instr(6'b000000, 0, 0);
    run_instr(6'b100011, 0, 3);
    run_instr(6'b000100, 0, 0);
    run_instr(6'b000010, 0, 0);
    run_instr(6'b111111, 0, 0);
    run_instr(6'b101011, 1, 2);

    // Reset while MEMWRITE is waiting abandons the store.
    op  = 6'b101011;
    rdy = 1'b1;
    cycle("mr_fetch", 4'd0, c_fr, 1'b0);
    cycle("mr_decode", 4'd1, c_dec, 1'b0);
    cycle("mr_memaddr", 4'd2, c_maddr, 1'b0);
    rdy = 1'b0;
    cycle("mr_wait", 4'd5, c_mwrite, 1'b0);
    rst = 1'b1;
    cycle("mr_reset", 4'd5, c_zero, 1'b0);
    model_count = 0;
    rst = 1'b0;
    cycle("mr_after", 4'd0, c_fw, 1'b0);
    rdy = 1'b1;
    cycle("mr_fetch2", 4'd0, c_fr, 1'b0);
    cycle("mr_decode2", 4'd1, c_dec, 1'b0);
    cycle("mr_memaddr2", 4'd2, c_maddr, 1'b0);
    cycle("mr_memwrite2", 4'd5, c_mwrite, 1'b1);

    // Random instruction mix with random wait lengths.
    ops[0] = 6'b000000;
    ops[1] = 6'b100011;
    ops[2] = 6'b101011;
    ops[3] = 6'b000100;
    ops[4] = 6'b000010;
    for (int k = 0; k < 40; k++) begin
      ops[5] = 6'($urandom);
      r = ops[$urandom_range(0, 5)];
      run_instr(r, $urandom_range(0, 2), $urandom_range(0, 3));
    end

    // Drive the counter to all-ones, then one more retirement wraps it.
    for (int k = 0; k < 20 && model_count != (1 << CW) - 1; k++) begin
      run_instr(6'b000010, 0, 0);
    end
    run_instr(6'b000010, 0, 0);
    #2;
    checks++;
    assert (cnt === '0) else begin
      errors++;
      $error("FAIL wrap count got %0d want 0", cnt);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
